// File: rtl/riscv_structures.sv
// Shared types and constants for the RV32I pipeline control logic.
package riscv_structures;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_e;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  // x0 is hard-wired to zero, so it never carries a dependency.
  function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// One pending bit per architectural register; clear is applied before set so
// a same-cycle clear/set of one register leaves it pending.
module reg_scoreboard
  import riscv_structures::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rs1_pending,
  output logic                  rs2_pending,
  output logic                  rd_pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_addr] = 1'b0;
    end
    if (set_en) begin
      pending_d[set_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Reads see registered state only; a retire this cycle is not bypassed.
  assign rs1_pending = pending_q[rs1_addr];
  assign rs2_pending = pending_q[rs2_addr];
  assign rd_pending  = pending_q[rd_addr];

endmodule

// File: rtl/pipeline_ctrl.sv
// Decode-stage issue controller: interlocks RAW/WAW hazards through a register
// scoreboard, bounds in-flight instructions and sequences the redirect flush.
module pipeline_ctrl
  import riscv_structures::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  de_valid,
  input  logic [REG_ADDR_W-1:0] de_rs1,
  input  logic [REG_ADDR_W-1:0] de_rs2,
  input  logic                  de_use_rs1,
  input  logic                  de_use_rs2,
  input  logic [REG_ADDR_W-1:0] de_rd,
  input  logic                  de_reg_write,
  input  logic                  redirect,
  input  logic                  retire_valid,
  input  logic [REG_ADDR_W-1:0] retire_rd,
  input  logic                  retire_clr,
  output logic                  issue,
  output logic                  stall,
  output logic                  flush,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_INFLIGHT);
  localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES);

  ctrl_state_e      state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  logic rs1_pending, rs2_pending, rd_pending;
  logic raw1, raw2, waw, full, hazard;
  logic sb_set_en, sb_clr_en;

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (sb_set_en),
    .set_addr    (de_rd),
    .clr_en      (sb_clr_en),
    .clr_addr    (retire_rd),
    .rs1_addr    (de_rs1),
    .rs2_addr    (de_rs2),
    .rd_addr     (de_rd),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .rd_pending  (rd_pending)
  );

  assign raw1   = de_use_rs1 & is_real_reg(de_rs1) & rs1_pending;
  assign raw2   = de_use_rs2 & is_real_reg(de_rs2) & rs2_pending;
  assign waw    = de_reg_write & is_real_reg(de_rd) & rd_pending;
  assign full   = (inflight_q == MAX_CNT);
  assign hazard = raw1 | raw2 | waw | full;

  assign sb_set_en = issue & de_reg_write & is_real_reg(de_rd);
  assign sb_clr_en = retire_valid & retire_clr & is_real_reg(retire_rd);

  // A redirect overrides everything: the decode instruction is on the wrong path.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    issue       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    if (redirect) begin
      flush       = 1'b1;
      state_d     = FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      case (state_q)
        RUN: begin
          issue = de_valid & ~hazard;
          stall = de_valid & hazard;
        end
        FLUSH: begin
          flush = 1'b1;
          if (flush_cnt_q == FC_W'(1)) begin
            state_d     = RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, retire_valid})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = (inflight_q == '0) ? '0 : inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  assign busy = (state_q != RUN) | (inflight_q != '0);

  a_no_retire_underflow: assert property (
    @(posedge clk) disable iff (rst) retire_valid |-> (inflight_q != '0)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a queue-based model
// of the instructions currently in flight.
module tb_pipeline_ctrl;

  localparam int MAX_INFLIGHT = 4;
  localparam int FLUSH_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       de_valid, de_use_rs1, de_use_rs2, de_reg_write;
  logic [4:0] de_rs1, de_rs2, de_rd;
  logic       redirect, retire_valid, retire_clr;
  logic [4:0] retire_rd;
  logic       issue, stall, flush, busy;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .de_valid     (de_valid),
    .de_rs1       (de_rs1),
    .de_rs2       (de_rs2),
    .de_use_rs1   (de_use_rs1),
    .de_use_rs2   (de_use_rs2),
    .de_rd        (de_rd),
    .de_reg_write (de_reg_write),
    .redirect     (redirect),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd),
    .retire_clr   (retire_clr),
    .issue        (issue),
    .stall        (stall),
    .flush        (flush),
    .busy         (busy)
  );

  // Model: every issued-but-not-retired instruction, plus flush cycles left.
  typedef struct packed {
    logic [4:0] rd;
    logic       sets;
  } inst_t;

  inst_t q[$];
  int    flush_left = 0;
  int    n_checks   = 0;
  int    n_errors   = 0;
  int    n_steps    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, n_steps);
    end
  endtask

  function automatic bit is_pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) begin
      if (q[i].sets && q[i].rd == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive_idle();
    de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0;
    de_rd = 0; de_reg_write = 0; redirect = 0;
    retire_valid = 0; retire_rd = 0; retire_clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    flush_left = 0;
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    $display("reset applied");
  endtask

  // One cycle: drive, compare against the model, then advance the model.
  task automatic step(input bit dv, input logic [4:0] rs1, input bit u1,
                      input logic [4:0] rs2, input bit u2,
                      input logic [4:0] rd, input bit rw,
                      input bit redir, input bit ret, input int ret_idx);
    bit    in_flush, hazard, exp_issue, exp_stall, exp_flush, exp_busy;
    int    idx;
    inst_t e;
    @(negedge clk);
    rst = 1'b0;
    de_valid = dv; de_rs1 = rs1; de_use_rs1 = u1; de_rs2 = rs2; de_use_rs2 = u2;
    de_rd = rd; de_reg_write = rw; redirect = redir;
    retire_valid = 0; retire_rd = 0; retire_clr = 0;
    idx = 0;
    if (ret && q.size() > 0) begin
      idx = ret_idx % q.size();
      retire_valid = 1'b1;
      retire_rd    = q[idx].rd;
      retire_clr   = q[idx].sets;
    end
    #1;
    in_flush  = flush_left > 0;
    hazard    = (u1 && is_pending(rs1)) || (u2 && is_pending(rs2)) ||
                (rw && is_pending(rd)) || (q.size() == MAX_INFLIGHT);
    exp_issue = !in_flush && dv && !hazard && !redir;
    exp_stall = !in_flush && dv && hazard && !redir;
    exp_flush = in_flush || redir;
    exp_busy  = in_flush || (q.size() != 0);
    chk("issue", 32'(issue), 32'(exp_issue));
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("flush", 32'(flush), 32'(exp_flush));
    chk("busy",  32'(busy),  32'(exp_busy));
    $display("step %0d dv=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b redir=%0b ret=%0b:%0d inflight=%0d -> issue=%0b stall=%0b flush=%0b busy=%0b",
             n_steps, dv, rs1, u1, rs2, u2, rd, rw, redir, retire_valid, retire_rd,
             q.size(), issue, stall, flush, busy);
    n_steps++;
    @(posedge clk);
    if (retire_valid) q.delete(idx);
    if (exp_issue) begin
      e.rd   = rd;
      e.sets = rw && (rd != 5'd0);
      q.push_back(e);
    end
    if (redir) flush_left = FLUSH_CYCLES;
    else if (flush_left > 0) flush_left--;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Dependent instruction: stalls until the cycle after rd=5 retires.
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 1, 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);

    // x0 is never pending.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);

    // Full: four independent issues, fifth stalls, retire frees a slot next cycle.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 5'(10 + i), 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 20, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 20, 1, 0, 0, 0);

    // Redirect, then a second redirect on the second flush cycle; drain.
    step(1, 0, 0, 0, 0, 21, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 21, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 21, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // WAW with simultaneous retire of the same register.
    do_reset();
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 7, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);

    // Reset in the middle of a flush with pending registers.
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 9, 1, 7, 1, 9, 1, 0, 0, 0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      bit dv, u1, u2, rw, redir, ret;
      logic [4:0] rs1, rs2, rd;
      dv    = $urandom_range(0, 9) < 8;
      u1    = $urandom_range(0, 1) == 1;
      u2    = $urandom_range(0, 1) == 1;
      rw    = $urandom_range(0, 3) != 0;
      rs1   = 5'($urandom_range(0, 7));
      rs2   = 5'($urandom_range(0, 7));
      rd    = 5'($urandom_range(0, 7));
      redir = $urandom_range(0, 19) == 0;
      ret   = $urandom_range(0, 9) < ((q.size() == MAX_INFLIGHT) ? 7 : 4);
      if (n == 750) do_reset();
      step(dv, rs1, u1, rs2, u2, rd, rw, redir, ret, int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
